// File: rtl/uart_receiver_if.sv
// Signal bundle between the oversampling receiver and its host.
// The host (master) drives the tick, the enable and the line; the receiver (slave) returns the frame results.
interface uart_receiver_if;
    logic       Rx_sample_ENABLE;
    logic       Rx_EN;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;
    logic       Rx_BUSY;

    modport master (
        output Rx_sample_ENABLE, Rx_EN, RxD,
        input  Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY
    );

    modport slave (
        input  Rx_sample_ENABLE, Rx_EN, RxD,
        output Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY
    );
endinterface

// File: rtl/uart_receiver.sv
// Oversampling 8E1 UART receiver; define RX_MAJORITY_VOTE_EN for 2-of-3 voting around mid-bit.
// state | meaning: IDLE wait start edge, START validate start, DATA 8 bits, PARITY parity bit, STOP stop bit.
module uart_receiver #(
    parameter int SAMPLES_PER_BIT = 16
) (
    input logic            clk,
    input logic            reset,
    uart_receiver_if.slave rx
);
    localparam int CW = $clog2(SAMPLES_PER_BIT);
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t M    = cnt_t'(SAMPLES_PER_BIT / 2 - 1);
    localparam cnt_t LAST = cnt_t'(SAMPLES_PER_BIT - 1);
`ifdef RX_MAJORITY_VOTE_EN
    localparam cnt_t D    = cnt_t'(SAMPLES_PER_BIT / 2);
`else
    localparam cnt_t D    = M;
`endif

    if (SAMPLES_PER_BIT < 8 || (SAMPLES_PER_BIT % 2) != 0) begin : g_bad_param
        $error("SAMPLES_PER_BIT must be even and at least 8");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state_q;
    cnt_t       cnt_q;
    logic [2:0] idx_q;
    logic       rxd_meta_q;
    logic       rxd_sync_q;
    logic [7:0] shift_q;
    logic       par_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic       perr_q;
    logic       ferr_q;
    logic       busy_q;
    logic       bit_val;

`ifdef RX_MAJORITY_VOTE_EN
    logic vote_a_q;
    logic vote_b_q;

    always_comb begin
        bit_val = (vote_a_q & vote_b_q) | (vote_a_q & rxd_sync_q) | (vote_b_q & rxd_sync_q);
    end
`else
    always_comb begin
        bit_val = rxd_sync_q;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            shift_q    <= '0;
            par_q      <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef RX_MAJORITY_VOTE_EN
            vote_a_q   <= 1'b1;
            vote_b_q   <= 1'b1;
`endif
        end else begin
            rxd_meta_q <= rx.RxD;
            rxd_sync_q <= rxd_meta_q;
            valid_q    <= 1'b0;

            if (!rx.Rx_EN) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                idx_q   <= '0;
                busy_q  <= 1'b0;
            end else if (rx.Rx_sample_ENABLE) begin
`ifdef RX_MAJORITY_VOTE_EN
                if (cnt_q == M - cnt_t'(1)) vote_a_q <= rxd_sync_q;
                if (cnt_q == M)             vote_b_q <= rxd_sync_q;
`endif
                case (state_q)
                    IDLE: begin
                        if (!rxd_sync_q) begin
                            state_q <= START;
                            cnt_q   <= '0;
                            idx_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    START: begin
                        if (cnt_q == D && bit_val) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end else if (cnt_q == LAST) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                            idx_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + cnt_t'(1);
                        end
                    end
                    DATA: begin
                        if (cnt_q == D) shift_q[idx_q] <= bit_val;
                        if (cnt_q == LAST) begin
                            cnt_q <= '0;
                            if (idx_q == 3'd7) state_q <= PARITY;
                            else               idx_q   <= idx_q + 3'd1;
                        end else begin
                            cnt_q <= cnt_q + cnt_t'(1);
                        end
                    end
                    PARITY: begin
                        if (cnt_q == D) par_q <= bit_val;
                        if (cnt_q == LAST) begin
                            state_q <= STOP;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + cnt_t'(1);
                        end
                    end
                    STOP: begin
                        // Finish at the stop-bit decision so a following start edge is not missed.
                        if (cnt_q == D) begin
                            data_q  <= shift_q;
                            perr_q  <= (^shift_q) ^ par_q;
                            ferr_q  <= ~bit_val;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + cnt_t'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx.Rx_DATA   = data_q;
    assign rx.Rx_VALID  = valid_q;
    assign rx.Rx_PERROR = perr_q;
    assign rx.Rx_FERROR = ferr_q;
    assign rx.Rx_BUSY   = busy_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames plus randomized frames against a frame-level model.
module tb_uart_receiver;
    localparam int S = 16;
    localparam int M = S / 2 - 1;
`ifdef RX_MAJORITY_VOTE_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif
    localparam int D = MAJ ? M + 1 : M;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uart_receiver_if rx_if();

    uart_receiver #(.SAMPLES_PER_BIT(S)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx_if)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int vcnt  = 0;
    logic line_q[$];

    always @(negedge clk) if (rx_if.Rx_VALID === 1'b1) vcnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One oversampling tick with the line already settled through the synchronizer.
    task automatic tick(input logic v);
        rx_if.RxD = v;
        repeat (3) @(negedge clk);
        rx_if.Rx_sample_ENABLE = 1'b1;
        @(negedge clk);
        rx_if.Rx_sample_ENABLE = 1'b0;
    endtask

    task automatic build_frame(input logic [7:0] d, input logic par, input logic stp);
        line_q.delete();
        repeat (S) line_q.push_back(1'b0);
        for (int k = 0; k < 8; k++) repeat (S) line_q.push_back(d[k]);
        repeat (S) line_q.push_back(par);
        repeat (S) line_q.push_back(stp);
        repeat (S) line_q.push_back(1'b1);
    endtask

    task automatic play(input int n, input string tag);
        for (int i = 0; i < n && i < line_q.size(); i++) begin
            tick(line_q[i]);
            if (i == 5 * S) check({tag, "_busy_mid"}, {31'd0, rx_if.Rx_BUSY}, 32'd1);
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input logic par_err,
                             input logic stop_err, input logic glitch);
        logic [7:0] exp_d;
        logic       par;
        int         v0;
        par = (^d) ^ par_err;
        build_frame(d, par, ~stop_err);
        if (glitch) line_q[S + 1 + M] = 1'b0;
        exp_d = d;
        if (glitch && !MAJ) exp_d[0] = 1'b0;
        v0 = vcnt;
        play(line_q.size(), tag);
        check({tag, "_valid"}, vcnt - v0, 32'd1);
        check({tag, "_data"}, {24'd0, rx_if.Rx_DATA}, {24'd0, exp_d});
        check({tag, "_perr"}, {31'd0, rx_if.Rx_PERROR}, {31'd0, (^exp_d) ^ par});
        check({tag, "_ferr"}, {31'd0, rx_if.Rx_FERROR}, {31'd0, stop_err});
        check({tag, "_busy_end"}, {31'd0, rx_if.Rx_BUSY}, 32'd0);
    endtask

    initial begin
        int       v0;
        logic [7:0] d0;
        rx_if.Rx_sample_ENABLE = 1'b0;
        rx_if.Rx_EN            = 1'b0;
        rx_if.RxD              = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data",  {24'd0, rx_if.Rx_DATA}, 32'd0);
        check("rst_valid", {31'd0, rx_if.Rx_VALID}, 32'd0);
        check("rst_perr",  {31'd0, rx_if.Rx_PERROR}, 32'd0);
        check("rst_ferr",  {31'd0, rx_if.Rx_FERROR}, 32'd0);
        check("rst_busy",  {31'd0, rx_if.Rx_BUSY}, 32'd0);
        reset = 1'b1;
        rx_if.Rx_EN = 1'b1;
        repeat (4) tick(1'b1);

        run_frame("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        run_frame("01_perr", 8'h01, 1'b1, 1'b0, 1'b0);
        run_frame("ff_ferr", 8'hFF, 1'b0, 1'b1, 1'b0);

        // Reset during data bit 3 must clear everything at once.
        build_frame(8'hC3, 1'b0, 1'b1);
        v0 = vcnt;
        play(4 * S + 5, "rst_mid");
        #2 reset = 1'b0;
        #1;
        check("rstmid_data",  {24'd0, rx_if.Rx_DATA}, 32'd0);
        check("rstmid_valid", {31'd0, rx_if.Rx_VALID}, 32'd0);
        check("rstmid_perr",  {31'd0, rx_if.Rx_PERROR}, 32'd0);
        check("rstmid_ferr",  {31'd0, rx_if.Rx_FERROR}, 32'd0);
        check("rstmid_busy",  {31'd0, rx_if.Rx_BUSY}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (S) tick(1'b1);
        check("rstmid_novalid", vcnt - v0, 32'd0);
        run_frame("3c", 8'h3C, 1'b0, 1'b0, 1'b0);

        // False start: line low 4 ticks, BUSY must drop at START decision tick.
        v0 = vcnt;
        d0 = rx_if.Rx_DATA;
        repeat (4) tick(1'b0);
        for (int j = 5; j <= D + 3; j++) begin
            tick(1'b1);
            if (j >= D + 1) check($sformatf("false_busy_t%0d", j), {31'd0, rx_if.Rx_BUSY},
                                  {31'd0, j < D + 2});
        end
        repeat (S) tick(1'b1);
        check("false_novalid", vcnt - v0, 32'd0);
        check("false_data", {24'd0, rx_if.Rx_DATA}, {24'd0, d0});

        run_frame("glitch", 8'h55, 1'b0, 1'b0, 1'b1);

        // Receiver disable mid-frame.
        build_frame(8'h96, 1'b0, 1'b1);
        play(3 * S, "en");
        check("en_busy_before", {31'd0, rx_if.Rx_BUSY}, 32'd1);
        v0 = vcnt;
        d0 = rx_if.Rx_DATA;
        rx_if.Rx_EN = 1'b0;
        @(negedge clk);
        check("en_busy_off", {31'd0, rx_if.Rx_BUSY}, 32'd0);
        check("en_valid_off", {31'd0, rx_if.Rx_VALID}, 32'd0);
        check("en_data_hold", {24'd0, rx_if.Rx_DATA}, {24'd0, d0});
        repeat (S) tick(1'b0);
        check("en_idle_busy", {31'd0, rx_if.Rx_BUSY}, 32'd0);
        repeat (S) tick(1'b1);
        check("en_novalid", vcnt - v0, 32'd0);
        rx_if.Rx_EN = 1'b1;
        repeat (S) tick(1'b1);
        run_frame("en_after", 8'h69, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            run_frame($sformatf("rnd%0d", r), 8'($urandom_range(0, 255)),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter SAMPLES_PER_BIT, default 16, giving the number of Rx_sample_ENABLE ticks per bit; it SHALL be even and >= 8.
REQ-002 SHALL have port clk, in, 1, the single system clock; all flops SHALL be clocked on its rising edge.
REQ-003 SHALL have port reset, in, 1, asynchronous active-low reset.
REQ-004 SHALL have port Rx_sample_ENABLE, in, 1, one-clk-wide oversampling tick issued SAMPLES_PER_BIT times per bit period.
REQ-005 SHALL have port Rx_EN, in, 1, receiver enable.
REQ-006 SHALL have port RxD, in, 1, asynchronous serial line; idle level is 1.
REQ-007 SHALL have port Rx_DATA, out, 8, last received byte.
REQ-008 SHALL have port Rx_VALID, out, 1, one-clk pulse marking a completed frame.
REQ-009 SHALL have port Rx_PERROR, out, 1, parity error of the last frame.
REQ-010 SHALL have port Rx_FERROR, out, 1, framing error (stop bit sampled 0) of the last frame.
REQ-011 SHALL have port Rx_BUSY, out, 1, high while a frame is in progress.

Function
REQ-012 SHALL receive the frame format: start bit 0, 8 data bits LSB first, 1 even-parity bit (XOR of the 8 data bits), 1 stop bit 1.
REQ-013 SHALL pass RxD through a 2-flop synchronizer clocked every clk; all line decisions SHALL use the synchronized value.
REQ-014 SHALL advance the state machine and the sample counter only on clk edges where Rx_sample_ENABLE=1.
REQ-015 SHALL define M = SAMPLES_PER_BIT/2 - 1 as the sample point and D as the decision tick: D = M, or M+1 under RX_MAJORITY_VOTE_EN.
REQ-016 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-017 In IDLE, a tick with synchronized RxD=0 SHALL move to START with counter=0.
REQ-018 In START, the counter SHALL increment each tick; at counter=D a sampled 1 SHALL return the block to IDLE with no flag or output change (false start).
REQ-019 In START, reaching counter=SAMPLES_PER_BIT-1 SHALL move to DATA with counter=0 and bit index=0.
REQ-020 In DATA, the value at D SHALL be stored at the current bit index; at counter=SAMPLES_PER_BIT-1 the block SHALL move to PARITY if the index is 7, else increment the index and clear the counter.
REQ-021 In PARITY, the value at D SHALL be stored; at the last tick the block SHALL move to STOP.
REQ-022 In STOP, at D the block SHALL load Rx_DATA, set Rx_PERROR = XOR(data) ^ parity, set Rx_FERROR = ~stop, pulse Rx_VALID for exactly one clk, and return to IDLE on the same tick to allow early resync.
REQ-023 Rx_DATA, Rx_PERROR and Rx_FERROR SHALL hold their values until the next frame completes; a completed frame with errors SHALL still load Rx_DATA.
REQ-024 Rx_BUSY SHALL be 1 in every state except IDLE.
REQ-025 Rx_EN=0 SHALL force IDLE, clear the counter and bit index and hold Rx_VALID=0 on the next clk, while Rx_DATA and the error flags hold their values.
REQ-026 A start edge arriving in the same tick that STOP completes SHALL be detected on the following tick.

Reset
REQ-027 reset=0 SHALL immediately force IDLE, counter=0, bit index=0, synchronizer flops=1, Rx_DATA=8'h00 and Rx_VALID=Rx_PERROR=Rx_FERROR=Rx_BUSY=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no Rx_VALID pulse.

Configuration
REQ-029 With RX_MAJORITY_VOTE_EN defined, each bit decision SHALL be the 2-of-3 majority of samples taken at counter M-1, M and M+1, decided at D=M+1.
REQ-030 Without RX_MAJORITY_VOTE_EN, each bit SHALL be the single sample at counter M, decided at D=M, and no vote logic SHALL be present.

Verification
REQ-031 Frame 0xA5, parity 0, stop 1 -> one Rx_VALID pulse, Rx_DATA=0xA5, Rx_PERROR=0, Rx_FERROR=0.
REQ-032 Frame 0x01 with parity 0 -> Rx_DATA=0x01, Rx_PERROR=1, Rx_FERROR=0.
REQ-033 Frame 0xFF, parity 0, stop 0 -> Rx_DATA=0xFF, Rx_FERROR=1, Rx_PERROR=0.
REQ-034 RxD low for 4 ticks then high -> no Rx_VALID, and Rx_BUSY falls at tick D of START.
REQ-035 reset pulsed low during data bit 3 -> all outputs 0 immediately; the following frame 0x3C is received with Rx_DATA=0x3C and no errors.
REQ-036 Data bit 0 = 1 with a one-tick low glitch at counter M -> received bit = 1 with RX_MAJORITY_VOTE_EN defined, and 0 without it.
